// File: rtl/udma_tx_wrr_sched.sv
// Weighted round-robin scheduler for the uDMA TX L2 read port.
// Limits per-channel outstanding reads with credit counters that responses release.
module udma_tx_wrr_sched #(
    parameter int N_CH         = 16,
    parameter int LOG_N_CH     = 4,
    parameter int WEIGHT_WIDTH = 4,
    parameter int MAX_OUTST    = 4,
    parameter int CREDIT_WIDTH = 3
) (
    input  logic                         clk_i,
    input  logic                         rstn_i,
    input  logic                         cfg_en_i,
    input  logic [N_CH-1:0]              req_i,
    input  logic [N_CH*WEIGHT_WIDTH-1:0] weight_i,
    output logic [N_CH-1:0]              grant_o,
    output logic [LOG_N_CH-1:0]          grant_id_o,
    output logic                         grant_valid_o,
    input  logic                         grant_ack_i,
    input  logic                         resp_i,
    input  logic [LOG_N_CH-1:0]          resp_id_i,
    output logic [N_CH-1:0]              credit_avail_o,
    output logic                         busy_o,
    output logic                         err_o
);

    // Handshake: a grant is transferred on any cycle where grant_valid_o and
    // grant_ack_i are both high; grant_o/grant_id_o are held stable until then.

    typedef enum logic {
        S_IDLE  = 1'b0,
        S_GRANT = 1'b1
    } state_e;

    state_e                  state_q, state_d;
    logic [CREDIT_WIDTH-1:0] outst_q [N_CH];
    logic [CREDIT_WIDTH-1:0] outst_d [N_CH];
    logic [LOG_N_CH-1:0]     owner_q, owner_d;
    logic [LOG_N_CH-1:0]     ptr_q, ptr_d;
    logic [LOG_N_CH-1:0]     next_start;
    logic [WEIGHT_WIDTH-1:0] wt_q, wt_d;
    logic [WEIGHT_WIDTH-1:0] burst_q, burst_d;
    logic [N_CH-1:0]         grant_q, grant_d;
    logic                    err_q, err_set;
    logic                    ack_fire;
    logic [N_CH-1:0]         inc_vec, dec_vec;
    logic [N_CH-1:0]         elig, elig_post;
    logic                    any_outst;
    logic [LOG_N_CH:0]       idle_pick, rel_pick;

    // Returns {found, index} of the first set bit of vec at or after start, wrapping.
    function automatic logic [LOG_N_CH:0] rr_pick(input logic [N_CH-1:0]     vec,
                                                  input logic [LOG_N_CH-1:0] start);
        logic [LOG_N_CH:0] res;
        int                j;
        res = '0;
        for (int k = N_CH - 1; k >= 0; k--) begin
            j = int'(start) + k;
            if (j >= N_CH) j = j - N_CH;
            if (vec[j]) res = {1'b1, LOG_N_CH'(j)};
        end
        return res;
    endfunction

    assign ack_fire = (state_q == S_GRANT) && grant_ack_i;

    always_comb begin
        inc_vec = '0;
        dec_vec = '0;
        for (int i = 0; i < N_CH; i++) begin
            inc_vec[i] = ack_fire && (owner_q == LOG_N_CH'(i));
            dec_vec[i] = resp_i && (resp_id_i == LOG_N_CH'(i));
        end
    end

    // Ack and response on the same channel cancel; a response with nothing
    // outstanding leaves the counter at zero and raises the sticky error.
    always_comb begin
        elig           = '0;
        elig_post      = '0;
        credit_avail_o = '0;
        any_outst      = 1'b0;
        for (int i = 0; i < N_CH; i++) begin
            outst_d[i] = outst_q[i];
            if (inc_vec[i] && !dec_vec[i]) begin
                outst_d[i] = outst_q[i] + 1'b1;
            end else if (!inc_vec[i] && dec_vec[i] && (outst_q[i] != '0)) begin
                outst_d[i] = outst_q[i] - 1'b1;
            end
            credit_avail_o[i] = outst_q[i] < CREDIT_WIDTH'(MAX_OUTST);
            elig[i]           = req_i[i] && credit_avail_o[i];
            elig_post[i]      = req_i[i] && (outst_d[i] < CREDIT_WIDTH'(MAX_OUTST));
            if (outst_q[i] != '0) any_outst = 1'b1;
        end
    end

    assign err_set = resp_i && (outst_q[resp_id_i] == '0) && !inc_vec[resp_id_i];

    assign next_start = (owner_q == LOG_N_CH'(N_CH - 1)) ? '0 : owner_q + 1'b1;
    assign idle_pick  = rr_pick(elig, ptr_q);
    assign rel_pick   = rr_pick(elig_post, next_start);

    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        ptr_d   = ptr_q;
        wt_d    = wt_q;
        burst_d = burst_q;
        case (state_q)
            S_IDLE: begin
                if (cfg_en_i && idle_pick[LOG_N_CH]) begin
                    state_d = S_GRANT;
                    owner_d = idle_pick[LOG_N_CH-1:0];
                    burst_d = '0;
                    wt_d    = weight_i[int'(idle_pick[LOG_N_CH-1:0])*WEIGHT_WIDTH +: WEIGHT_WIDTH];
                end
            end
            S_GRANT: begin
                if (grant_ack_i) begin
                    if (cfg_en_i && elig_post[owner_q] && (burst_q < wt_q)) begin
                        burst_d = burst_q + 1'b1;
                    end else begin
                        ptr_d = next_start;
                        if (cfg_en_i && rel_pick[LOG_N_CH]) begin
                            owner_d = rel_pick[LOG_N_CH-1:0];
                            burst_d = '0;
                            wt_d    = weight_i[int'(rel_pick[LOG_N_CH-1:0])*WEIGHT_WIDTH +: WEIGHT_WIDTH];
                        end else begin
                            state_d = S_IDLE;
                        end
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        grant_d = '0;
        if (state_d == S_GRANT) grant_d = N_CH'(1) << owner_d;
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state_q <= S_IDLE;
            owner_q <= '0;
            ptr_q   <= '0;
            wt_q    <= '0;
            burst_q <= '0;
            grant_q <= '0;
            err_q   <= 1'b0;
            for (int i = 0; i < N_CH; i++) outst_q[i] <= '0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            ptr_q   <= ptr_d;
            wt_q    <= wt_d;
            burst_q <= burst_d;
            grant_q <= grant_d;
            if (err_set) err_q <= 1'b1;
            for (int i = 0; i < N_CH; i++) outst_q[i] <= outst_d[i];
        end
    end

    assign grant_valid_o = (state_q == S_GRANT);
    assign grant_id_o    = owner_q;
    assign grant_o       = grant_q;
    assign busy_o        = grant_valid_o | any_outst;
    assign err_o         = err_q;

endmodule

// File: tb/tb_udma_tx_wrr_sched.sv
// Directed testbench for udma_tx_wrr_sched: credits, weighted bursts, wrap, errors, reset.
module tb_udma_tx_wrr_sched;

    localparam int N_CH = 16;
    localparam int LOG_N_CH = 4;
    localparam int WW = 4;

    logic                 clk;
    logic                 rstn;
    logic                 cfg_en;
    logic [N_CH-1:0]      req;
    logic [N_CH*WW-1:0]   weight;
    logic [N_CH-1:0]      grant;
    logic [LOG_N_CH-1:0]  grant_id;
    logic                 grant_valid;
    logic                 grant_ack;
    logic                 resp;
    logic [LOG_N_CH-1:0]  resp_id;
    logic [N_CH-1:0]      credit_avail;
    logic                 busy;
    logic                 err;

    int errors = 0;
    int checks = 0;

    udma_tx_wrr_sched dut (
        .clk_i          (clk),
        .rstn_i         (rstn),
        .cfg_en_i       (cfg_en),
        .req_i          (req),
        .weight_i       (weight),
        .grant_o        (grant),
        .grant_id_o     (grant_id),
        .grant_valid_o  (grant_valid),
        .grant_ack_i    (grant_ack),
        .resp_i         (resp),
        .resp_id_i      (resp_id),
        .credit_avail_o (credit_avail),
        .busy_o         (busy),
        .err_o          (err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rstn      = 1'b0;
        cfg_en    = 1'b1;
        req       = '0;
        weight    = '0;
        grant_ack = 1'b0;
        resp      = 1'b0;
        resp_id   = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rstn = 1'b1;
        tick();
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if (grant_valid !== 1'b0 || grant !== 16'h0 || grant_id !== 4'h0) begin
            errors++;
            $display("FAIL reset_grant: valid=%0b grant=%h id=%0d, required 0/0000/0", grant_valid, grant, grant_id);
        end
        checks++;
        if (credit_avail !== 16'hFFFF || busy !== 1'b0 || err !== 1'b0) begin
            errors++;
            $display("FAIL reset_status: credit=%h busy=%0b err=%0b, required ffff/0/0", credit_avail, busy, err);
        end
    endtask

    task automatic test_credit_limit();
        do_reset();
        req       = 16'h0008;
        grant_ack = 1'b1;
        tick();
        for (int n = 0; n < 4; n++) begin
            checks++;
            if (grant_valid !== 1'b1 || grant_id !== 4'd3 || grant !== 16'h0008) begin
                errors++;
                $display("FAIL credit_grant%0d: valid=%0b id=%0d grant=%h, required 1/3/0008", n, grant_valid, grant_id, grant);
            end
            tick();
        end
        checks++;
        if (grant_valid !== 1'b0 || credit_avail[3] !== 1'b0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL credit_exhausted: valid=%0b credit3=%0b busy=%0b, required 0/0/1", grant_valid, credit_avail[3], busy);
        end
        grant_ack = 1'b0;
        resp      = 1'b1;
        resp_id   = 4'd3;
        tick();
        resp = 1'b0;
        checks++;
        if (credit_avail[3] !== 1'b1) begin
            errors++;
            $display("FAIL credit_release: credit3=%0b, required 1", credit_avail[3]);
        end
        tick();
        checks++;
        if (grant_valid !== 1'b1 || grant_id !== 4'd3) begin
            errors++;
            $display("FAIL credit_regrant: valid=%0b id=%0d, required 1/3", grant_valid, grant_id);
        end
    endtask

    task automatic test_weighted_burst();
        logic [LOG_N_CH-1:0] exp_q[$];
        exp_q = '{4'd0, 4'd0, 4'd0, 4'd1, 4'd0, 4'd0, 4'd0, 4'd1};
        do_reset();
        weight[3:0] = 4'd2;
        weight[7:4] = 4'd0;
        req         = 16'h0003;
        grant_ack   = 1'b1;
        tick();
        for (int k = 0; k < 8; k++) begin
            checks++;
            if (grant_valid !== 1'b1 || grant_id !== exp_q[k]) begin
                errors++;
                $display("FAIL wrr_seq%0d: valid=%0b id=%0d, required 1/%0d", k, grant_valid, grant_id, exp_q[k]);
            end
            if (k > 0) begin
                resp    = 1'b1;
                resp_id = exp_q[k-1];
            end
            tick();
        end
        grant_ack = 1'b0;
        resp      = 1'b0;
    endtask

    task automatic test_wrap_around();
        do_reset();
        req = 16'h4000;
        tick();
        checks++;
        if (grant_valid !== 1'b1 || grant_id !== 4'd14) begin
            errors++;
            $display("FAIL wrap_ch14: valid=%0b id=%0d, required 1/14", grant_valid, grant_id);
        end
        req       = 16'h8004;
        grant_ack = 1'b1;
        tick();
        checks++;
        if (grant_valid !== 1'b1 || grant_id !== 4'd15 || grant !== 16'h8000) begin
            errors++;
            $display("FAIL wrap_ch15: valid=%0b id=%0d grant=%h, required 1/15/8000", grant_valid, grant_id, grant);
        end
        tick();
        checks++;
        if (grant_valid !== 1'b1 || grant_id !== 4'd2) begin
            errors++;
            $display("FAIL wrap_ch2: valid=%0b id=%0d, required 1/2", grant_valid, grant_id);
        end
        tick();
        checks++;
        if (grant_valid !== 1'b1 || grant_id !== 4'd15) begin
            errors++;
            $display("FAIL wrap_ch15_again: valid=%0b id=%0d, required 1/15", grant_valid, grant_id);
        end
        grant_ack = 1'b0;
    endtask

    task automatic test_ack_resp_same_cycle();
        do_reset();
        req       = 16'h0020;
        grant_ack = 1'b1;
        repeat (3) tick();
        checks++;
        if (grant_valid !== 1'b1 || grant_id !== 4'd5 || credit_avail[5] !== 1'b1) begin
            errors++;
            $display("FAIL sim_setup: valid=%0b id=%0d credit5=%0b, required 1/5/1", grant_valid, grant_id, credit_avail[5]);
        end
        resp    = 1'b1;
        resp_id = 4'd5;
        tick();
        resp = 1'b0;
        checks++;
        if (credit_avail[5] !== 1'b1 || grant_valid !== 1'b1) begin
            errors++;
            $display("FAIL sim_same_cycle: credit5=%0b valid=%0b, required 1/1", credit_avail[5], grant_valid);
        end
        tick();
        checks++;
        if (credit_avail[5] !== 1'b1) begin
            errors++;
            $display("FAIL sim_count3: credit5=%0b, required 1", credit_avail[5]);
        end
        tick();
        checks++;
        if (credit_avail[5] !== 1'b0 || grant_valid !== 1'b0) begin
            errors++;
            $display("FAIL sim_count4: credit5=%0b valid=%0b, required 0/0", credit_avail[5], grant_valid);
        end
        grant_ack = 1'b0;
    endtask

    task automatic test_error_enable();
        do_reset();
        resp    = 1'b1;
        resp_id = 4'd7;
        tick();
        resp = 1'b0;
        checks++;
        if (err !== 1'b1 || credit_avail !== 16'hFFFF) begin
            errors++;
            $display("FAIL err_set: err=%0b credit=%h, required 1/ffff", err, credit_avail);
        end
        repeat (3) tick();
        checks++;
        if (err !== 1'b1) begin
            errors++;
            $display("FAIL err_sticky: err=%0b, required 1", err);
        end
        req = 16'h0002;
        tick();
        cfg_en = 1'b0;
        req    = '0;
        repeat (3) tick();
        checks++;
        if (grant_valid !== 1'b1 || grant_id !== 4'd1 || grant !== 16'h0002) begin
            errors++;
            $display("FAIL en_hold: valid=%0b id=%0d grant=%h, required 1/1/0002", grant_valid, grant_id, grant);
        end
        req       = 16'h0002;
        grant_ack = 1'b1;
        tick();
        grant_ack = 1'b0;
        checks++;
        if (grant_valid !== 1'b0 || grant !== 16'h0) begin
            errors++;
            $display("FAIL en_release: valid=%0b grant=%h, required 0/0000", grant_valid, grant);
        end
        tick();
        checks++;
        if (grant_valid !== 1'b0 || err !== 1'b1) begin
            errors++;
            $display("FAIL en_stay_idle: valid=%0b err=%0b, required 0/1", grant_valid, err);
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        req       = 16'h0200;
        grant_ack = 1'b1;
        repeat (3) tick();
        grant_ack = 1'b0;
        checks++;
        if (grant_valid !== 1'b1 || busy !== 1'b1) begin
            errors++;
            $display("FAIL rmid_setup: valid=%0b busy=%0b, required 1/1", grant_valid, busy);
        end
        #2;
        rstn = 1'b0;
        #1;
        checks++;
        if (grant_valid !== 1'b0 || grant !== 16'h0 || grant_id !== 4'h0 ||
            credit_avail !== 16'hFFFF || busy !== 1'b0 || err !== 1'b0) begin
            errors++;
            $display("FAIL rmid_async: valid=%0b grant=%h id=%0d credit=%h busy=%0b err=%0b, required 0/0000/0/ffff/0/0",
                     grant_valid, grant, grant_id, credit_avail, busy, err);
        end
        @(negedge clk);
        rstn = 1'b1;
        req  = 16'h0040;
        tick();
        checks++;
        if (grant_valid !== 1'b1 || grant_id !== 4'd6 || grant !== 16'h0040) begin
            errors++;
            $display("FAIL rmid_first_grant: valid=%0b id=%0d grant=%h, required 1/6/0040", grant_valid, grant_id, grant);
        end
    endtask

    initial begin
        test_reset();
        test_credit_limit();
        test_weighted_burst();
        test_wrap_around();
        test_ack_resp_same_cycle();
        test_error_enable();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
